// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and FSM encodings; CKSUM states exist only under UART_FRAME_CKSUM_EN
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE, LEN_H, LEN_L, CMD, PAYLOAD
`ifdef UART_FRAME_CKSUM_EN
    , CKSUM
`endif
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_SYNC, T_LEN_H, T_LEN_L, T_TYPE, T_DATA,
`ifdef UART_FRAME_CKSUM_EN
    T_CKSUM,
`endif
    T_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_frame_fifo.sv
// rtl/uart_frame_fifo.sv - per-channel byte FIFO, pushes while full are dropped
module uart_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_frame_mux.sv
// rtl/uart_frame_mux.sv - UART frame parser/framer over NUM_CH byte channels; UART_FRAME_CKSUM_EN adds a trailing XOR byte
module uart_frame_mux
  import uart_frame_pkg::*;
#(
  parameter int         NUM_CH       = 4,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         MAX_BURST    = 8,
  parameter logic [7:0] RX_CMD_BASE  = 8'h0C,
  parameter logic [7:0] TX_TYPE_BASE = 8'h06,
  parameter int         RX_TIMEOUT   = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [8*NUM_CH-1:0]   rx_ch_data,
  output logic [NUM_CH-1:0]     rx_ch_we,
  input  logic [8*NUM_CH-1:0]   tx_ch_data,
  input  logic [NUM_CH-1:0]     tx_ch_we,
  output logic [NUM_CH-1:0]     tx_ch_full,
  output logic                  rx_err
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);

  rx_state_t        rx_state, rx_next;
  logic [15:0]      len_q, len_n, cnt_q, cnt_n;
  logic [7:0]       cmd_q, cmd_n, rx_idx;
  logic [TO_W-1:0]  to_cnt;
  logic [NUM_CH-1:0] we_n;
  logic             err_n, rx_hit;

  assign rx_idx = cmd_q - RX_CMD_BASE;
  assign rx_hit = (rx_idx < 8'(NUM_CH));

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] rx_ck, rx_ck_n;
  always_comb begin
    rx_ck_n = rx_ck;
    if (rx_valid && (rx_state inside {LEN_H, LEN_L, CMD, PAYLOAD}))
      rx_ck_n = (rx_state == LEN_H) ? rx_data : (rx_ck ^ rx_data);
  end
`endif

  always_comb begin
    rx_next = rx_state;
    len_n   = len_q;
    cnt_n   = cnt_q;
    cmd_n   = cmd_q;
    we_n    = '0;
    err_n   = 1'b0;
    // Timeout only while a frame is in progress; any rx_valid resets it
    if (rx_state != IDLE && !rx_valid && to_cnt == TO_W'(RX_TIMEOUT - 1)) begin
      rx_next = IDLE;
      err_n   = 1'b1;
    end else if (rx_valid) begin
      case (rx_state)
        IDLE:  if (rx_data == SYNC_BYTE) rx_next = LEN_H;
        LEN_H: begin
          len_n   = {rx_data, 8'h00};
          rx_next = LEN_L;
        end
        LEN_L: begin
          len_n = {len_q[15:8], rx_data};
          if ({len_q[15:8], rx_data} == 16'd0) begin
            rx_next = IDLE;
            err_n   = 1'b1;
          end else rx_next = CMD;
        end
        CMD: begin
          cmd_n = rx_data;
          cnt_n = '0;
`ifdef UART_FRAME_CKSUM_EN
          rx_next = (len_q == 16'd1) ? CKSUM : PAYLOAD;
`else
          rx_next = (len_q == 16'd1) ? IDLE : PAYLOAD;
`endif
        end
        PAYLOAD: begin
          if (rx_hit) we_n = NUM_CH'(1) << rx_idx[2:0];
          cnt_n = cnt_q + 16'd1;
`ifdef UART_FRAME_CKSUM_EN
          if (cnt_q + 16'd1 == len_q - 16'd1) rx_next = CKSUM;
`else
          if (cnt_q + 16'd1 == len_q - 16'd1) rx_next = IDLE;
`endif
        end
`ifdef UART_FRAME_CKSUM_EN
        CKSUM: begin
          err_n   = (rx_data != rx_ck);
          rx_next = IDLE;
        end
`endif
        default: rx_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      to_cnt     <= '0;
      rx_ch_we   <= '0;
      rx_ch_data <= '0;
      rx_err     <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      rx_ck      <= '0;
`endif
    end else begin
      rx_state <= rx_next;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      cmd_q    <= cmd_n;
      rx_ch_we <= we_n;
      rx_err   <= err_n;
      to_cnt   <= (rx_state == IDLE || rx_valid) ? '0 : to_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (we_n[i]) rx_ch_data[8*i +: 8] <= rx_data;
`ifdef UART_FRAME_CKSUM_EN
      rx_ck    <= rx_ck_n;
`endif
    end
  end

  logic [7:0]      fifo_dout  [NUM_CH];
  logic [CW-1:0]   fifo_count [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty, fifo_pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    uart_frame_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(tx_ch_we[g]), .din(tx_ch_data[8*g +: 8]),
      .pop(fifo_pop[g]), .dout(fifo_dout[g]), .full(tx_ch_full[g]),
      .empty(fifo_empty[g]), .count(fifo_count[g])
    );
  end

  tx_state_t       tx_state, tx_next;
  logic [CH_W-1:0] cur_ch, cur_n, rr_ptr, rr_n, sel_idx, cand;
  logic [7:0]      n_q, n_n, d_cnt, d_n, data_n;
  logic [15:0]     tx_len;
  logic            sel_found, start_n, can_send;

  assign tx_len   = {8'h00, n_q} + 16'd1;
  assign can_send = !tx_busy && !tx_start;

  // Round-robin search begins at the channel after the one last served
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!sel_found && !fifo_empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] tx_ck, tx_ck_n;
  always_comb begin
    tx_ck_n = tx_ck;
    if (start_n && (tx_state inside {T_LEN_H, T_LEN_L, T_TYPE, T_DATA}))
      tx_ck_n = (tx_state == T_LEN_H) ? data_n : (tx_ck ^ data_n);
  end
`endif

  always_comb begin
    tx_next  = tx_state;
    cur_n    = cur_ch;
    n_n      = n_q;
    d_n      = d_cnt;
    rr_n     = rr_ptr;
    start_n  = 1'b0;
    data_n   = tx_data;
    fifo_pop = '0;
    case (tx_state)
      T_IDLE: if (sel_found) begin
        cur_n   = sel_idx;
        n_n     = (int'(fifo_count[sel_idx]) > MAX_BURST) ? 8'(MAX_BURST) : 8'(fifo_count[sel_idx]);
        d_n     = '0;
        rr_n    = (int'(sel_idx) == NUM_CH - 1) ? '0 : sel_idx + 1'b1;
        tx_next = T_SYNC;
      end
      T_SYNC:  if (can_send) begin start_n = 1'b1; data_n = SYNC_BYTE;    tx_next = T_LEN_H; end
      T_LEN_H: if (can_send) begin start_n = 1'b1; data_n = tx_len[15:8]; tx_next = T_LEN_L; end
      T_LEN_L: if (can_send) begin start_n = 1'b1; data_n = tx_len[7:0];  tx_next = T_TYPE;  end
      T_TYPE:  if (can_send) begin
        start_n = 1'b1;
        data_n  = TX_TYPE_BASE + 8'(cur_ch);
        tx_next = T_DATA;
      end
      T_DATA: if (can_send) begin
        start_n          = 1'b1;
        data_n           = fifo_dout[cur_ch];
        fifo_pop[cur_ch] = 1'b1;
        d_n              = d_cnt + 8'd1;
`ifdef UART_FRAME_CKSUM_EN
        if (d_cnt + 8'd1 == n_q) tx_next = T_CKSUM;
`else
        if (d_cnt + 8'd1 == n_q) tx_next = T_DONE;
`endif
      end
`ifdef UART_FRAME_CKSUM_EN
      T_CKSUM: if (can_send) begin start_n = 1'b1; data_n = tx_ck; tx_next = T_DONE; end
`endif
      default: if (can_send) tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= T_IDLE;
      cur_ch   <= '0;
      rr_ptr   <= '0;
      n_q      <= '0;
      d_cnt    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
`ifdef UART_FRAME_CKSUM_EN
      tx_ck    <= '0;
`endif
    end else begin
      tx_state <= tx_next;
      cur_ch   <= cur_n;
      rr_ptr   <= rr_n;
      n_q      <= n_n;
      d_cnt    <= d_n;
      tx_start <= start_n;
      tx_data  <= data_n;
`ifdef UART_FRAME_CKSUM_EN
      tx_ck    <= tx_ck_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_frame_mux.sv
// tb/tb_uart_frame_mux.sv - directed bench for uart_frame_mux (default build, UART_FRAME_CKSUM_EN undefined)
module tb_uart_frame_mux;
  localparam int NUM_CH = 4, FIFO_DEPTH = 16, MAX_BURST = 8, RX_TIMEOUT = 50;

  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  rx_data = '0, tx_data;
  logic        rx_valid = 1'b0, tx_start, tx_busy = 1'b0, rx_err;
  logic [31:0] rx_ch_data, tx_ch_data = '0;
  logic [3:0]  rx_ch_we, tx_ch_we = '0, tx_ch_full;

  uart_frame_mux #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST),
                   .RX_CMD_BASE(8'h0C), .TX_TYPE_BASE(8'h06), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_ch_data(rx_ch_data), .rx_ch_we(rx_ch_we),
    .tx_ch_data(tx_ch_data), .tx_ch_we(tx_ch_we), .tx_ch_full(tx_ch_full), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Receiver-side monitors and a UART transmitter model with a 3-cycle busy per byte
  logic [15:0] rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  exp_tx[$];
  int          err_cnt = 0, busy_cnt = 0;
  logic        busy_hold = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (rx_ch_we[i]) rxq.push_back({8'(i), rx_ch_data[8*i +: 8]});
    if (rx_err) err_cnt++;
    if (tx_start) begin
      txq.push_back(tx_data);
      busy_cnt = 3;
    end else if (busy_cnt > 0) busy_cnt--;
    tx_busy = busy_hold || (busy_cnt != 0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[8*i +: 8]);
  endtask

  task automatic push(input logic [3:0] we, input logic [31:0] d);
    @(negedge clk); tx_ch_we = we; tx_ch_data = d;
    @(negedge clk); tx_ch_we = '0;
  endtask

  task automatic exp_frame(input int ch, input int n, input logic [7:0] first);
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'(n + 1));
    exp_tx.push_back(8'(8'h06 + ch));
    for (int k = 0; k < n; k++) exp_tx.push_back(first + 8'(k));
  endtask

  task automatic expect_tx(input string tag, input int base);
    int t;
    t = 0;
    while (txq.size() - base < exp_tx.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    idle(40);
    check({tag, "_count"}, txq.size() - base, exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (base + i < txq.size()) ? txq[base + i] : 8'hxx, exp_tx[i]);
    exp_tx.delete();
  endtask

  int rb, eb, tb;
  initial begin
    idle(3);
    check("rst_rx_ch_we", rx_ch_we, 0);
    check("rst_rx_ch_data", rx_ch_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_tx_ch_full", tx_ch_full, 0);
    @(negedge clk); reset = 1'b0;
    idle(2);

    rb = rxq.size(); eb = err_cnt;
    send_seq(64'hAA_00_03_0D_5A_A5, 6); idle(3);
    check("ch1_count", rxq.size() - rb, 2);
    check("ch1_byte0", rxq[rb], 16'h015A);
    check("ch1_byte1", rxq[rb + 1], 16'h01A5);
    check("ch1_no_err", err_cnt - eb, 0);

    rb = rxq.size(); eb = err_cnt;
    send_seq(64'hAA_00_02_20_77, 5); idle(3);
    check("nomatch_strobes", rxq.size() - rb, 0);
    check("nomatch_err", err_cnt - eb, 0);
    send_seq(64'hAA_00_00, 3); idle(3);
    check("len0_err", err_cnt - eb, 1);
    send_seq(64'hAA_00_02_0E_44, 5); idle(3);
    check("after_len0_count", rxq.size() - rb, 1);
    check("after_len0_ch2", rxq[rb], 16'h0244);

    rb = rxq.size(); eb = err_cnt;
    send_seq(64'hAA_00_01_0D, 4);
    send_seq(64'hAA_00_02_0D_66, 5); idle(3);
    check("len1_count", rxq.size() - rb, 1);
    check("len1_next_frame", rxq[rb], 16'h0166);
    check("len1_no_err", err_cnt - eb, 0);

    rb = rxq.size(); eb = err_cnt;
    send_seq(64'hAA_00_05_0C_11, 5); idle(2);
    check("partial_ch0", rxq[rb], 16'h0011);
    idle(RX_TIMEOUT - 5);
    check("timeout_not_early", err_cnt - eb, 0);
    idle(10);
    check("timeout_err", err_cnt - eb, 1);
    send_seq(64'hAA_00_02_0C_22, 5); idle(3);
    check("post_timeout_count", rxq.size() - rb, 2);
    check("post_timeout_ch0", rxq[rb + 1], 16'h0022);

    rb = rxq.size(); eb = err_cnt;
    send_seq(64'hAA_00_03_0D, 4);
    @(negedge clk); reset = 1'b1;
    idle(2); reset = 1'b0;
    send(8'h5A); send(8'hA5); idle(3);
    check("midreset_no_strobes", rxq.size() - rb, 0);
    check("midreset_no_err", err_cnt - eb, 0);

    // A one-byte blocker on ch0 holds the framer so ch2 can be filled to 10
    tb = txq.size();
    busy_hold = 1'b1; idle(2);
    push(4'b0001, 32'h0000_0011); idle(3);
    for (int i = 0; i < 10; i++) push(4'b0100, (32'h30 + i) << 16);
    busy_hold = 1'b0;
    exp_frame(0, 1, 8'h11); exp_frame(2, 8, 8'h30); exp_frame(2, 2, 8'h38);
    expect_tx("burst", tb);

    // Blocker on ch3 moves the round-robin pointer to 0 before ch0/ch3 contend
    tb = txq.size();
    busy_hold = 1'b1; idle(2);
    push(4'b1000, 32'h5000_0000); idle(3);
    push(4'b1001, 32'h7000_0060);
    busy_hold = 1'b0;
    exp_frame(3, 1, 8'h50); exp_frame(0, 1, 8'h60); exp_frame(3, 1, 8'h70);
    expect_tx("rr", tb);

    tb = txq.size();
    busy_hold = 1'b1; idle(2);
    for (int i = 0; i < 17; i++) push(4'b0010, (32'h80 + i) << 8);
    idle(1);
    check("ch1_full", tx_ch_full, 4'b0010);
    busy_hold = 1'b0;
    exp_frame(1, 1, 8'h80); exp_frame(1, 8, 8'h81); exp_frame(1, 7, 8'h89);
    expect_tx("full_drop", tb);
    check("full_cleared", tx_ch_full, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_mux.md
UART_FRAME_MUX -- requirements
Module: uart_frame_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of RX and TX byte channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, per-TX-channel FIFO depth in bytes (power of two, >=2).
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum payload bytes per transmitted frame (1..255).
REQ-004 SHALL have parameter RX_CMD_BASE, default 8'h0C; RX channel i accepts cmd RX_CMD_BASE+i.
REQ-005 SHALL have parameter TX_TYPE_BASE, default 8'h06; TX channel i frames carry type TX_TYPE_BASE+i.
REQ-006 SHALL have parameter RX_TIMEOUT, default 200000, idle clk cycles that abort a partial RX frame.
REQ-007 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have ports rx_data  in  8, and rx_valid  in  1, a one-cycle pulse marking a byte from the UART receiver.
REQ-010 SHALL have ports tx_data  out  8, tx_start  out  1 (one-cycle pulse) and tx_busy  in  1, all to the UART transmitter.
REQ-011 SHALL have ports rx_ch_data  out  8*NUM_CH and rx_ch_we  out  NUM_CH, giving decoded payload byte and per-channel strobe.
REQ-012 SHALL have ports tx_ch_data  in  8*NUM_CH, tx_ch_we  in  NUM_CH and tx_ch_full  out  NUM_CH, the per-channel FIFO write side.
REQ-013 SHALL have port rx_err  out  1, a one-cycle pulse on malformed, timed-out or (if enabled) bad-checksum frame.

Function
REQ-014 RX parser SHALL use states IDLE, LEN_H, LEN_L, CMD, PAYLOAD (plus CKSUM if enabled), advancing only on rx_valid; IDLE leaves only on byte 8'hAA.
REQ-015 Frame length SHALL be 16-bit big-endian and count cmd plus payload; len==0 SHALL return to IDLE at LEN_L with rx_err; len==1 SHALL go CMD->IDLE with no payload.
REQ-016 Each payload byte for a matching cmd SHALL appear on its rx_ch_data slice with rx_ch_we high exactly one cycle, the cycle after its rx_valid; other channels' strobes stay low.
REQ-017 Payload of non-matching cmds SHALL be consumed silently, with no strobes and no rx_err.
REQ-018 PAYLOAD SHALL return to IDLE after exactly len-1 bytes; the payload counter SHALL be 16-bit and never wrap before len-1.
REQ-019 With the parser outside IDLE and RX_TIMEOUT cycles without rx_valid, it SHALL return to IDLE and pulse rx_err; rx_valid restarts the count.
REQ-020 Each TX channel SHALL own a FIFO; a write when full SHALL be dropped; tx_ch_full SHALL equal count==FIFO_DEPTH; simultaneous push and pop on one FIFO SHALL both take effect.
REQ-021 TX framer SHALL use states T_IDLE, T_SYNC, T_LEN_H, T_LEN_L, T_TYPE, T_DATA, (T_CKSUM), T_DONE.
REQ-022 In T_IDLE it SHALL select the next non-empty channel round-robin, starting after the last channel served (channel 0 first after reset).
REQ-023 At selection it SHALL latch n = min(count, MAX_BURST) and len = n+1; bytes pushed later SHALL NOT extend that frame.
REQ-024 Each byte (8'hAA, len_hi, len_lo, type, n data) SHALL be issued only when !tx_busy && !tx_start, one tx_start pulse per byte.
REQ-025 Each data byte SHALL be popped from the FIFO in the same cycle its tx_start is issued.
REQ-026 T_DONE SHALL wait for !tx_busy && !tx_start, then go to T_IDLE.

Reset
REQ-027 On reset, both FSMs SHALL go to IDLE/T_IDLE, all FIFOs empty, round-robin pointer 0 and timeout counter 0.
REQ-028 On reset, rx_ch_we, rx_ch_data, tx_start, tx_data and rx_err SHALL be 0 and tx_ch_full 0.
REQ-029 Reset mid-frame SHALL abandon the frame; no partial frame resumes.

Configuration
REQ-030 With UART_FRAME_CKSUM_EN defined, each frame SHALL carry a trailing byte not counted in len, equal to the XOR of len_hi, len_lo, cmd/type and payload.
REQ-031 Under UART_FRAME_CKSUM_EN, TX SHALL append the checksum; RX SHALL check it in CKSUM and pulse rx_err on mismatch; already delivered payload is not retracted.
REQ-032 Without UART_FRAME_CKSUM_EN, no checksum byte SHALL be sent or expected, and CKSUM/T_CKSUM SHALL not exist.

Structure
REQ-033 Package uart_frame_pkg SHALL hold SYNC_BYTE=8'hAA and the RX and TX state encodings.
REQ-034 Sub-module uart_frame_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated once per TX channel.

Verification
REQ-035 RX AA 00 03 0D 5A A5 -> rx_ch_we[1] pulses twice, data 5A then A5; no other strobes.
REQ-036 RX AA 00 02 20 77 -> no strobes, no rx_err; then AA 00 00 -> rx_err pulse, parser IDLE.
REQ-037 RX AA 00 05 0C 11, then silence RX_TIMEOUT cycles -> rx_err; next AA 00 02 0C 22 -> ch0 gets 22.
REQ-038 Push 10 bytes ch2, MAX_BURST=8 -> TX AA 00 09 08 + 8 bytes, then AA 00 03 08 + 2 bytes.
REQ-039 ch0 and ch3 both hold 1 byte -> ch0 frame type 06, then ch3 frame type 09; 17th push to ch1 at depth 16 dropped, tx_ch_full high.
REQ-040 With UART_FRAME_CKSUM_EN: RX AA 00 02 0C 33 3D -> ch0 gets 33, no rx_err; trailing byte 3E -> rx_err.
